// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one 8N1 UART transmit line between NumReq byte-stream requesters.
//   A round-robin arbiter picks the next byte while the serialiser is idle.
//   With LineLock=1 a requester that starts a text line keeps the line until
//   it sends 0x0A or stays silent for IdleTimeout cycles, so lines never
//   interleave.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   req_valid_i  [NumReq]    byte available, one bit per requester
//   req_data_i   [NumReq*8]  byte for requester i in bits [8i+7:8i]
//   req_ready_o  [NumReq]    one-cycle accept pulse (one-hot, only with valid)
//   tx_o         serial output, idle high
//   busy_o       high while a frame is being shifted
//   grant_o      index of the current/last granted requester
//   lock_o       high while the line lock is held
module uart_tx_arbiter #(
  parameter int NumReq         = 4,
  parameter int ClockFrequency = 30_000_000,
  parameter int BaudRate       = 115_200,
  parameter int LineLock       = 1,
  parameter int IdleTimeout    = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*8-1:0]       req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] grant_o,
  output logic                      lock_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int IW = $clog2(NumReq);
  localparam int CW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int TW = (IdleTimeout > 1) ? $clog2(IdleTimeout) : 1;

  localparam logic [CW-1:0] BitLast     = CW'(ClksPerBit - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(IdleTimeout - 1);
  localparam logic [IW-1:0] ReqLast     = IW'(NumReq - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic            lock_reg, lock_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;

  logic [7:0]        req_byte [NumReq];
  logic [NumReq-1:0] eligible;
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic              accept;
  int                arb_sum;
  logic [IW-1:0]     arb_cand;

  // Per-requester byte slices, eligibility and ready decode. While the lock
  // is held only the owner (the last granted requester) may compete.
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
      assign req_byte[gi]    = req_data_i[8*gi +: 8];
      assign eligible[gi]    = req_valid_i[gi] & (~lock_reg | (grant_reg == IW'(gi)));
      assign req_ready_o[gi] = accept & (win_idx == IW'(gi));
    end
  endgenerate

  // Round-robin search: first eligible index at or after the pointer,
  // wrapping modulo NumReq (NumReq need not be a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_sum   = 0;
    arb_cand  = '0;
    for (int k = 0; k < NumReq; k++) begin
      arb_sum = int'(ptr_reg) + k;
      if (arb_sum >= NumReq) begin
        arb_sum = arb_sum - NumReq;
      end
      arb_cand = IW'(arb_sum);
      if (!win_found && eligible[arb_cand]) begin
        win_found = 1'b1;
        win_idx   = arb_cand;
      end
    end
  end

  // Ready is combinational so the accept happens in the arbitration cycle;
  // it is masked during reset so a reset cycle never completes a handshake.
  assign accept = (state_reg == IDLE) & win_found & ~rst_i;

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    lock_next    = lock_reg;
    to_cnt_next  = to_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          shift_next   = req_byte[win_idx];
          grant_next   = win_idx;
          ptr_next     = (win_idx == ReqLast) ? '0 : win_idx + IW'(1);
          to_cnt_next  = '0;
          clk_cnt_next = '0;
          tx_next      = 1'b0;
          state_next   = START;
          if (LineLock != 0) begin
            lock_next = (req_byte[win_idx] != 8'h0A);
          end
        end else if (lock_reg) begin
          // Locked with no winner means the owner has nothing to send.
          // The release lands on the edge, so the following cycle
          // arbitrates among everybody.
          if (to_cnt_reg == TimeoutLast) begin
            lock_next   = 1'b0;
            to_cnt_next = '0;
          end else begin
            to_cnt_next = to_cnt_reg + TW'(1);
          end
        end
      end

      START: begin
        if (clk_cnt_reg == BitLast) begin
          clk_cnt_next = '0;
          bit_cnt_next = 3'd0;
          tx_next      = shift_reg[0];
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt_reg == BitLast) begin
          clk_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end

      STOP: begin
        if (clk_cnt_reg == BitLast) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      grant_reg   <= '0;
      ptr_reg     <= '0;
      lock_reg    <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      lock_reg    <= lock_next;
      to_cnt_reg  <= to_cnt_next;
    end
  end

  assign tx_o    = tx_reg;
  assign busy_o  = (state_reg != IDLE);
  assign grant_o = grant_reg;
  assign lock_o  = lock_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Instance 0 runs with LineLock=1, instance 1
// with LineLock=0. Expected grants and line bytes are queued when stimulus
// is set up; monitors pop and compare them on ready pulses and on frames.
module tb_uart_tx_arbiter;

  localparam int Cpb         = 260;
  localparam int FramePeriod = 10 * Cpb + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]      valid [2];
  logic [3:0][7:0] data  [2];
  logic [3:0]      ready [2];
  logic            tx    [2];
  logic            busy  [2];
  logic [1:0]      grant [2];
  logic            lock  [2];

  logic [3:0] acc_mask       [2];
  logic       mon_active     [2];
  int         last_ready_cyc [2];
  logic       chk_gap        [2];

  int         exp_req_q  [2][$];
  logic [7:0] exp_byte_q [2][$];
  logic [7:0] src_q      [8][$];
  logic       en         [8];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      uart_tx_arbiter #(
        .NumReq(4), .ClockFrequency(30_000_000), .BaudRate(115_200),
        .LineLock((gi == 0) ? 1 : 0), .IdleTimeout(1024)
      ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(valid[gi]),
        .req_data_i (data[gi]),
        .req_ready_o(ready[gi]),
        .tx_o       (tx[gi]),
        .busy_o     (busy[gi]),
        .grant_o    (grant[gi]),
        .lock_o     (lock[gi])
      );

      // Ready monitor: handshake legality, grant order, lock and grant_o
      // one cycle after each accept, and back-to-back frame period.
      initial begin : rdy_mon
        int         idx;
        logic [7:0] b;
        logic       lock_chk;
        logic       exp_lock;
        int         exp_grant;
        logic       have_prev;
        int         prev_cyc;
        idx = 0; b = 8'h00; lock_chk = 1'b0; exp_lock = 1'b0;
        exp_grant = 0; have_prev = 1'b0; prev_cyc = 0;
        forever begin
          @(negedge clk);
          acc_mask[gi] = 4'd0;
          if (rst) begin
            lock_chk = 1'b0;
          end else begin
            if (lock_chk) begin
              check_value("lock_after_accept", 32'(lock[gi]), 32'(exp_lock));
              check_value("grant_o", 32'(grant[gi]), 32'(exp_grant));
              lock_chk = 1'b0;
            end
            if (ready[gi] != 4'd0) begin
              acc_mask[gi] = ready[gi];
              check_value("ready_onehot", 32'($onehot(ready[gi])), 32'd1);
              check_value("ready_without_valid", 32'(ready[gi] & ~valid[gi]), 32'd0);
              idx = 0;
              for (int r = 3; r >= 0; r--) begin
                if (ready[gi][r]) idx = r;
              end
              b = data[gi][idx];
              $display("[TB] dut%0d accept req%0d byte 0x%02h at cycle %0d", gi, idx, b, cyc);
              if (exp_req_q[gi].size() == 0) begin
                check_value("ready_unexpected", 32'(idx), 32'd99);
              end else begin
                check_value("grant_order", 32'(idx), 32'(exp_req_q[gi].pop_front()));
              end
              exp_grant = idx;
              exp_lock  = (gi == 0) && (b != 8'h0A);
              lock_chk  = 1'b1;
              if (chk_gap[gi] && have_prev) begin
                check_value("frame_period", 32'(cyc - prev_cyc), 32'(FramePeriod));
              end
              have_prev = 1'b1;
              prev_cyc  = cyc;
              last_ready_cyc[gi] = cyc;
            end
          end
        end
      end

      // Line monitor: checks the first and last cycle of every bit cell of a
      // frame against the expected byte, then busy/tx right after the stop.
      initial begin : line_mon
        int         off;
        logic [9:0] frame;
        logic [7:0] eb;
        logic [3:0] bit_idx;
        off = 0; frame = 10'h3FF; eb = 8'h00; bit_idx = 4'd0;
        forever begin
          @(negedge clk);
          if (rst) begin
            mon_active[gi] = 1'b0;
          end else begin
            if (!mon_active[gi] && tx[gi] == 1'b0) begin
              mon_active[gi] = 1'b1;
              off = 0;
              check_value("start_latency", 32'(cyc - last_ready_cyc[gi]), 32'd1);
              if (exp_byte_q[gi].size() == 0) begin
                check_value("frame_unexpected", 32'(exp_byte_q[gi].size()), 32'd1);
                eb = 8'h00;
              end else begin
                eb = exp_byte_q[gi].pop_front();
              end
              frame = {1'b1, eb, 1'b0};
            end
            if (mon_active[gi]) begin
              if (off < 10 * Cpb) begin
                bit_idx = 4'(off / Cpb);
                if ((off % Cpb) == 0 || (off % Cpb) == Cpb - 1) begin
                  check_value($sformatf("tx_bit%0d_byte%02h", bit_idx, eb), 32'(tx[gi]), 32'(frame[bit_idx]));
                  check_value("busy_in_frame", 32'(busy[gi]), 32'd1);
                end
              end else begin
                check_value("busy_after_stop", 32'(busy[gi]), 32'd0);
                check_value("tx_idle_after_stop", 32'(tx[gi]), 32'd1);
                mon_active[gi] = 1'b0;
              end
              off++;
            end
          end
        end
      end
    end
  endgenerate

  // Requester model: holds valid and the head byte until accepted.
  initial begin : driver
    logic       k;
    logic [1:0] r;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        k = (i >= 4);
        r = 2'(i % 4);
        if (acc_mask[k][r] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (en[i] && src_q[i].size() > 0) begin
          valid[k][r] = 1'b1;
          data[k][r]  = src_q[i][0];
        end else begin
          valid[k][r] = 1'b0;
        end
      end
    end
  end

  task automatic queue_byte(input logic [2:0] slot, input logic [7:0] b);
    src_q[slot].push_back(b);
  endtask

  task automatic expect_byte(input logic inst, input int req, input logic [7:0] b);
    exp_req_q[inst].push_back(req);
    exp_byte_q[inst].push_back(b);
  endtask

  task automatic wait_drain(input logic inst, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_req_q[inst].size() != 0 || exp_byte_q[inst].size() != 0 ||
            mon_active[inst] || busy[inst]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value("drain_in_time", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_accept(input logic inst, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (exp_req_q[inst].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value("accept_in_time", 32'(n < budget), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    for (int i = 0; i < 8; i++) en[i] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 4'd0; data[i] = '0; acc_mask[i] = 4'd0;
      mon_active[i] = 1'b0; last_ready_cyc[i] = 0; chk_gap[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_value("reset_tx", 32'(tx[i]), 32'd1);
      check_value("reset_busy", 32'(busy[i]), 32'd0);
      check_value("reset_ready", 32'(ready[i]), 32'd0);
      check_value("reset_grant", 32'(grant[i]), 32'd0);
      check_value("reset_lock", 32'(lock[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Pure round-robin (instance 1): all four requesters always valid.
    chk_gap[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 4; r++) begin
        queue_byte(3'(4 + r), 8'(8'h41 + 4 * k + r));
        expect_byte(1'b1, r, 8'(8'h41 + 4 * k + r));
      end
    end
    wait_drain(1'b1, 9 * FramePeriod);
    chk_gap[1] = 1'b0;

    // Single byte 0x55 from req0, then a newline to release the lock.
    queue_byte(3'd0, 8'h55); expect_byte(1'b0, 0, 8'h55);
    queue_byte(3'd0, 8'h0A); expect_byte(1'b0, 0, 8'h0A);
    wait_drain(1'b0, 3 * FramePeriod);
    check_value("lock_clear_after_nl", 32'(lock[0]), 32'd0);

    // req1 owns the line for "ab\n" while req0 waits with valid high.
    queue_byte(3'd1, 8'h61); queue_byte(3'd1, 8'h62); queue_byte(3'd1, 8'h0A);
    queue_byte(3'd0, 8'h5A); queue_byte(3'd0, 8'h0A);
    expect_byte(1'b0, 1, 8'h61); expect_byte(1'b0, 1, 8'h62); expect_byte(1'b0, 1, 8'h0A);
    expect_byte(1'b0, 0, 8'h5A); expect_byte(1'b0, 0, 8'h0A);
    wait_drain(1'b0, 6 * FramePeriod);

    // Lock timeout: req2 sends 'x' and goes quiet; req3 waits for release.
    queue_byte(3'd2, 8'h78); expect_byte(1'b0, 2, 8'h78);
    wait_accept(1'b0, 2 * FramePeriod);
    t0 = last_ready_cyc[0];
    queue_byte(3'd3, 8'h71); queue_byte(3'd3, 8'h0A);
    expect_byte(1'b0, 3, 8'h71); expect_byte(1'b0, 3, 8'h0A);
    while (cyc < t0 + FramePeriod + 1023) @(negedge clk);
    check_value("lock_before_timeout", 32'(lock[0]), 32'd1);
    check_value("no_grant_while_locked", 32'(ready[0]), 32'd0);
    @(negedge clk);
    check_value("lock_after_timeout", 32'(lock[0]), 32'd0);
    check_value("req3_grant_after_timeout", 32'(ready[0]), 32'h8);
    wait_drain(1'b0, 3 * FramePeriod);

    // Reset in the middle of data bit 3, then a clean 0xA5 frame.
    queue_byte(3'd0, 8'hC3); expect_byte(1'b0, 0, 8'hC3);
    wait_accept(1'b0, 2 * FramePeriod);
    t0 = last_ready_cyc[0];
    while (cyc < t0 + 1100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_value("midreset_tx", 32'(tx[0]), 32'd1);
    check_value("midreset_busy", 32'(busy[0]), 32'd0);
    check_value("midreset_ready", 32'(ready[0]), 32'd0);
    check_value("midreset_lock", 32'(lock[0]), 32'd0);
    check_value("midreset_grant", 32'(grant[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    queue_byte(3'd0, 8'hA5); expect_byte(1'b0, 0, 8'hA5);
    queue_byte(3'd0, 8'h0A); expect_byte(1'b0, 0, 8'h0A);
    wait_drain(1'b0, 3 * FramePeriod);

    // req2 raises then drops valid during a frame; pointer order is 3 then 0.
    queue_byte(3'd1, 8'h0A); expect_byte(1'b0, 1, 8'h0A);
    wait_accept(1'b0, 2 * FramePeriod);
    queue_byte(3'd2, 8'h6B);
    repeat (300) @(negedge clk);
    en[2] = 1'b0;
    queue_byte(3'd3, 8'h0A); expect_byte(1'b0, 3, 8'h0A);
    queue_byte(3'd0, 8'h0A); expect_byte(1'b0, 0, 8'h0A);
    wait_drain(1'b0, 4 * FramePeriod);
    src_q[2].delete();
    en[2] = 1'b1;

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmit line between NumReq byte-stream requesters, e.g. several software/hardware log sources feeding the single system UART that the simulation UART DPI model or the board FTDI bridge observes.
- Round-robin arbitration with optional line locking: once a requester starts a text line, it keeps the line until newline or timeout, so lines never interleave.
- Contains the baud-rate generator and serialiser.

Parameters:
- NumReq, 4, number of requesters (2..8).
- ClockFrequency, 30_000_000, clk_i frequency in Hz.
- BaudRate, 115_200, line rate. ClksPerBit = ClockFrequency/BaudRate, integer divide (260 at defaults).
- LineLock, 1, 1 = hold grant until 0x0A is sent or timeout; 0 = pure per-byte round-robin.
- IdleTimeout, 1024, cycles a locked requester may leave valid low before its lock is dropped.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NumReq  byte available, one bit per requester.
- req_data_i  in  NumReq*8  byte for requester i in bits [8i+7:8i].
- req_ready_o  out  NumReq  one-cycle accept pulse, one bit per requester.
- tx_o  out  1  serial output, idle high.
- busy_o  out  1  high while a frame is being shifted.
- grant_o  out  $clog2(NumReq)  index of the current/last granted requester.
- lock_o  out  1  high while line lock is held.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: tx_o=1, req_ready_o=0, busy_o=0, grant_o=0, lock_o=0; round-robin pointer=0, so requester 0 has highest priority first; bit counter=0; timeout counter=0.
- Handshake:
  - A transfer occurs when req_valid_i[i] & req_ready_o[i].
  - req_ready_o[i] is asserted only when req_valid_i[i] is high, is at most one-hot, and lasts one cycle.
  - A requester holds valid and data stable until accepted; valid may drop without acceptance.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Select a winner among valid requesters.
  - If locked: only the lock owner is eligible.
  - If not locked: the first valid index at or after the pointer, modulo NumReq.
  - If a winner exists, in the same cycle: pulse ready, latch data into the shift register, set grant_o, set pointer to winner+1 (mod NumReq), go to START.
- START: tx_o=0 for ClksPerBit cycles, then DATA.
- DATA: 8 bits, LSB first, each held ClksPerBit cycles, then STOP.
- STOP: tx_o=1 for ClksPerBit cycles, then IDLE.
- busy_o is high in START, DATA and STOP.
- Latency: tx_o falls on the cycle after the ready pulse.
- Frame period: minimum 10*ClksPerBit+1 cycles per byte (one IDLE cycle between frames).
- Lock rules (LineLock=1):
  - On acceptance of a byte != 0x0A, lock to the winner.
  - On acceptance of 0x0A, clear the lock.
  - While locked in IDLE with the owner's valid low, the timeout counter increments; it clears on any acceptance.
  - When the counter reaches IdleTimeout-1, the lock clears and the next cycle arbitrates round-robin among all requesters.
  - The counter does not run during a frame.
- LineLock=0: lock_o stays 0 and the timeout counter is unused.
- lock_o reflects the lock register.
- Simultaneous events: requests arriving during a frame wait; arbitration happens only in IDLE.
- A lock release by timeout and a new request from another requester in the same cycle: the release takes effect first, and that requester is granted in the following cycle.
- Reset mid-frame: the next cycle has tx_o=1 and all state at reset values; the partial byte is dropped and no ready pulse is issued.

Test Plan:
- Reset, then req0 sends 0x55 ->
  - ready[0] pulses at cycle T.
  - tx_o low over T+1..T+260; data bits 1,0,1,0,1,0,1,0 at 260-cycle intervals; stop high.
  - busy_o low again at T+2601.
- req0..req3 all hold valid with distinct non-newline bytes, LineLock=0 -> accept order 0,1,2,3,0,1..., frame period exactly 2601 cycles.
- LineLock=1: req1 sends 'a','b',0x0A while req0 holds valid throughout -> req0 is not accepted until after 0x0A; lock_o falls at 0x0A acceptance.
- LineLock=1: req2 sends 'x' then drops valid; req3 valid -> lock held through the frame, released after 1024 idle cycles, req3 granted on the next cycle.
- Reset asserted during data bit 3 -> tx_o=1 and busy_o=0 the next cycle, no ready pulse; the following 0xA5 frame is clean.
- req_valid_i drops before acceptance (during a busy frame) -> no ready pulse to that requester; the next valid requester is granted in pointer order.
